// File: rtl/pipelined_adder.sv
`default_nettype none
// =============================================================================
// Module   : pipelined_adder
// Purpose  : WIDTH-bit adder split into STAGES carry-chained register stages,
//            valid/ready handshake, carry/overflow flags, wrap or saturate.
// Revision : 1.0  initial release
// =============================================================================
module pipelined_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   input  logic             sat_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CHUNK   = WIDTH / STAGES;
   localparam int LAST_LO = WIDTH - CHUNK;
   localparam logic [LAST_LO:0] LAST_MASK = ((LAST_LO+1)'(1) << LAST_LO) - (LAST_LO+1)'(1);

   logic             advance;
   logic             last_v;
   logic [LAST_LO:0] last_acc;
   logic [CHUNK-1:0] last_a;
   logic [CHUNK-1:0] last_b;
   logic             last_sgn;
   logic             last_sat;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             overflow_q, overflow_d;

   // The whole pipe moves together; only a held output blocks it.
   assign advance  = ~(out_valid_q & ~out_ready);
   assign in_ready = advance;

   // Each intermediate stage keeps {carry, low partial sum} in acc_q and only
   // the operand bits still to be added in a_q/b_q.
   genvar s;
   generate
      for (s = 0; s < STAGES-1; s++) begin : g_stage
         localparam int LO = s * CHUNK;
         localparam int RW = WIDTH - LO;
         localparam int AW = LO + CHUNK + 1;
         localparam logic [LO:0] LO_MASK = ((LO+1)'(1) << LO) - (LO+1)'(1);

         logic                v_in, sgn_in, sat_in;
         logic [LO:0]         acc_in;
         logic [RW-1:0]       a_in, b_in;
         logic [CHUNK:0]      part;
         logic                v_q, v_d;
         logic                sgn_q, sgn_d;
         logic                sat_q, sat_d;
         logic [AW-1:0]       acc_q, acc_d;
         logic [RW-CHUNK-1:0] a_q, a_d;
         logic [RW-CHUNK-1:0] b_q, b_d;

         if (s == 0) begin : g_src_port
            assign v_in   = in_valid;
            assign acc_in = '0;
            assign a_in   = a;
            assign b_in   = b;
            assign sgn_in = signed_mode;
            assign sat_in = sat_en;
         end else begin : g_src_prev
            assign v_in   = g_stage[s-1].v_q;
            assign acc_in = g_stage[s-1].acc_q;
            assign a_in   = g_stage[s-1].a_q;
            assign b_in   = g_stage[s-1].b_q;
            assign sgn_in = g_stage[s-1].sgn_q;
            assign sat_in = g_stage[s-1].sat_q;
         end

         always_comb begin
            part  = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, acc_in[LO]};
            v_d   = v_q;
            sgn_d = sgn_q;
            sat_d = sat_q;
            acc_d = acc_q;
            a_d   = a_q;
            b_d   = b_q;
            if (advance) begin
               v_d   = v_in;
               sgn_d = sgn_in;
               sat_d = sat_in;
               acc_d = (AW'(part) << LO) | AW'(acc_in & LO_MASK);
               a_d   = a_in[RW-1:CHUNK];
               b_d   = b_in[RW-1:CHUNK];
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_q   <= 1'b0;
               sgn_q <= 1'b0;
               sat_q <= 1'b0;
               acc_q <= '0;
               a_q   <= '0;
               b_q   <= '0;
            end else begin
               v_q   <= v_d;
               sgn_q <= sgn_d;
               sat_q <= sat_d;
               acc_q <= acc_d;
               a_q   <= a_d;
               b_q   <= b_d;
            end
         end
      end

      if (STAGES == 1) begin : g_last_port
         assign last_v   = in_valid;
         assign last_acc = '0;
         assign last_a   = a;
         assign last_b   = b;
         assign last_sgn = signed_mode;
         assign last_sat = sat_en;
      end else begin : g_last_prev
         assign last_v   = g_stage[STAGES-2].v_q;
         assign last_acc = g_stage[STAGES-2].acc_q;
         assign last_a   = g_stage[STAGES-2].a_q;
         assign last_b   = g_stage[STAGES-2].b_q;
         assign last_sgn = g_stage[STAGES-2].sgn_q;
         assign last_sat = g_stage[STAGES-2].sat_q;
      end
   endgenerate

   logic [CHUNK:0]   last_part;
   logic [WIDTH:0]   full;
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] sat_val;
   logic             c_raw;
   logic             v_raw;
   logic             use_sat;

   // Final chunk, flags and saturation feed the output register directly.
   always_comb begin
      last_part = {1'b0, last_a} + {1'b0, last_b} + {{CHUNK{1'b0}}, last_acc[LAST_LO]};
      full      = ((WIDTH+1)'(last_part) << LAST_LO) | (WIDTH+1)'(last_acc & LAST_MASK);
      raw       = full[WIDTH-1:0];
      c_raw     = full[WIDTH];
      v_raw     = (last_a[CHUNK-1] == last_b[CHUNK-1]) & (raw[WIDTH-1] != last_a[CHUNK-1]);
      if (last_sgn) begin
         sat_val = last_a[CHUNK-1] ? (WIDTH'(1) << (WIDTH-1)) : ~(WIDTH'(1) << (WIDTH-1));
      end else begin
         sat_val = '1;
      end
      use_sat     = last_sat & (last_sgn ? v_raw : c_raw);

      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      overflow_d  = overflow_q;
      if (advance) begin
         out_valid_d = last_v;
         if (last_v) begin
            sum_d      = use_sat ? sat_val : raw;
            carry_d    = c_raw;
            overflow_d = last_sgn ? v_raw : c_raw;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         overflow_q  <= overflow_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign carry_out = carry_q;
   assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// =============================================================================
// Module   : tb_pipelined_adder
// Purpose  : directed checks of an 8-bit/2-stage and a 16-bit/4-stage adder.
// Revision : 1.0  initial release
// =============================================================================
module tb_pipelined_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        iv8, ir8, sg8, st8, ov8, or8, c8, v8;
   logic [7:0]  a8, b8, s8;
   logic        iv16, ir16, sg16, st16, ov16, or16, c16, v16;
   logic [15:0] a16, b16, s16;

   int errors = 0;
   int checks = 0;

   pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .signed_mode(sg8), .sat_en(st8), .out_valid(ov8), .out_ready(or8),
      .sum(s8), .carry_out(c8), .overflow(v8));

   pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .signed_mode(sg16), .sat_en(st16), .out_valid(ov16), .out_ready(or16),
      .sum(s16), .carry_out(c16), .overflow(v16));

   // One transaction on the 8-bit DUT; modes are flipped once idle to show they are not resampled.
   task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic sg, input logic st,
                       output logic [7:0] rs, output logic rc, output logic rv, output int lat);
      @(negedge clk);
      a8 = x; b8 = y; sg8 = sg; st8 = st; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0; sg8 = ~sg; st8 = ~st;
      lat = 1;
      while (ov8 !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      rs = s8; rc = c8; rv = v8;
   endtask

   task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic sg, input logic st,
                        output logic [15:0] rs, output logic rc, output logic rv, output int lat);
      @(negedge clk);
      a16 = x; b16 = y; sg16 = sg; st16 = st; iv16 = 1'b1;
      @(negedge clk);
      iv16 = 1'b0; sg16 = ~sg; st16 = ~st;
      lat = 1;
      while (ov16 !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      rs = s16; rc = c16; rv = v16;
   endtask

   task automatic test_reset();
      int seen;
      rst_n = 1'b0; iv8 = 1'b1; iv16 = 1'b1;
      a8 = 8'd5; b8 = 8'd6; a16 = 16'd7; b16 = 16'd8;
      repeat (2) @(negedge clk);
      checks++; if (ov8 !== 1'b0)   begin errors++; $display("FAIL reset out_valid8: got %b expected 0", ov8); end
      checks++; if (s8 !== 8'h00)   begin errors++; $display("FAIL reset sum8: got %h expected 00", s8); end
      checks++; if (c8 !== 1'b0)    begin errors++; $display("FAIL reset carry8: got %b expected 0", c8); end
      checks++; if (v8 !== 1'b0)    begin errors++; $display("FAIL reset ovf8: got %b expected 0", v8); end
      checks++; if (ov16 !== 1'b0)  begin errors++; $display("FAIL reset out_valid16: got %b expected 0", ov16); end
      checks++; if (s16 !== 16'h0)  begin errors++; $display("FAIL reset sum16: got %h expected 0000", s16); end
      rst_n = 1'b1; iv8 = 1'b0; iv16 = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (ov8 !== 1'b0 || ov16 !== 1'b0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL reset no_output: got %0d valid cycles expected 0", seen); end
   endtask

   task automatic test_unsigned();
      logic [7:0] rs; logic rc, rv; int lat;
      run8(8'd100, 8'd20, 1'b0, 1'b0, rs, rc, rv, lat);
      checks++; if (lat != 2)      begin errors++; $display("FAIL u100_20 latency: got %0d expected 2", lat); end
      checks++; if (rs !== 8'd120) begin errors++; $display("FAIL u100_20 sum: got %0d expected 120", rs); end
      checks++; if (rc !== 1'b0)   begin errors++; $display("FAIL u100_20 carry: got %b expected 0", rc); end
      checks++; if (rv !== 1'b0)   begin errors++; $display("FAIL u100_20 ovf: got %b expected 0", rv); end
      run8(8'd200, 8'd100, 1'b0, 1'b0, rs, rc, rv, lat);
      checks++; if (rs !== 8'd44)  begin errors++; $display("FAIL u200_100_wrap sum: got %0d expected 44", rs); end
      checks++; if (rc !== 1'b1)   begin errors++; $display("FAIL u200_100_wrap carry: got %b expected 1", rc); end
      checks++; if (rv !== 1'b1)   begin errors++; $display("FAIL u200_100_wrap ovf: got %b expected 1", rv); end
      run8(8'd200, 8'd100, 1'b0, 1'b1, rs, rc, rv, lat);
      checks++; if (rs !== 8'd255) begin errors++; $display("FAIL u200_100_sat sum: got %0d expected 255", rs); end
      checks++; if (rc !== 1'b1)   begin errors++; $display("FAIL u200_100_sat carry: got %b expected 1", rc); end
      checks++; if (rv !== 1'b1)   begin errors++; $display("FAIL u200_100_sat ovf: got %b expected 1", rv); end
   endtask

   task automatic test_signed();
      logic [7:0] rs; logic rc, rv; int lat;
      run8(8'h64, 8'h64, 1'b1, 1'b1, rs, rc, rv, lat);
      checks++; if (rs !== 8'h7F) begin errors++; $display("FAIL s_pos_sat sum: got %h expected 7f", rs); end
      checks++; if (rv !== 1'b1)  begin errors++; $display("FAIL s_pos_sat ovf: got %b expected 1", rv); end
      checks++; if (rc !== 1'b0)  begin errors++; $display("FAIL s_pos_sat carry: got %b expected 0", rc); end
      run8(8'h9C, 8'h9C, 1'b1, 1'b1, rs, rc, rv, lat);
      checks++; if (rs !== 8'h80) begin errors++; $display("FAIL s_neg_sat sum: got %h expected 80", rs); end
      checks++; if (rv !== 1'b1)  begin errors++; $display("FAIL s_neg_sat ovf: got %b expected 1", rv); end
      checks++; if (rc !== 1'b1)  begin errors++; $display("FAIL s_neg_sat carry: got %b expected 1", rc); end
      run8(8'h64, 8'h64, 1'b1, 1'b0, rs, rc, rv, lat);
      checks++; if (rs !== 8'hC8) begin errors++; $display("FAIL s_pos_wrap sum: got %h expected c8", rs); end
      checks++; if (rv !== 1'b1)  begin errors++; $display("FAIL s_pos_wrap ovf: got %b expected 1", rv); end
      run8(8'h9C, 8'h9C, 1'b1, 1'b0, rs, rc, rv, lat);
      checks++; if (rs !== 8'h38) begin errors++; $display("FAIL s_neg_wrap sum: got %h expected 38", rs); end
      checks++; if (rc !== 1'b1)  begin errors++; $display("FAIL s_neg_wrap carry: got %b expected 1", rc); end
   endtask

   // Streams i+i for i=1..10 with out_ready low in cycles 5..7.
   task automatic test_back_to_back();
      int idx, got, extra;
      logic [7:0] held;
      logic stalled_prev;
      idx = 1; got = 0; held = '0; stalled_prev = 1'b0;
      sg8 = 1'b0; st8 = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
         @(negedge clk);
         or8 = !(cyc >= 5 && cyc <= 7);
         iv8 = (idx <= 10);
         a8  = idx[7:0];
         b8  = idx[7:0];
         #1;
         if (ov8 === 1'b1 && or8 === 1'b0) begin
            checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL b2b stall_in_ready: got %b expected 0", ir8); end
            if (stalled_prev) begin
               checks++; if (s8 !== held) begin errors++; $display("FAIL b2b stall_sum_stable: got %0d expected %0d", s8, held); end
            end
            held = s8;
            stalled_prev = 1'b1;
         end else begin
            stalled_prev = 1'b0;
         end
         if (ov8 === 1'b1 && or8 === 1'b1) begin
            got++;
            checks++; if (s8 !== 8'(2 * got)) begin errors++; $display("FAIL b2b result%0d: got %0d expected %0d", got, s8, 2 * got); end
         end
         if (iv8 === 1'b1 && ir8 === 1'b1) idx++;
      end
      iv8 = 1'b0; or8 = 1'b1;
      checks++; if (got != 10) begin errors++; $display("FAIL b2b result_count: got %0d expected 10", got); end
      checks++; if (idx != 11) begin errors++; $display("FAIL b2b accept_count: got %0d expected 10", idx - 1); end
      extra = 0;
      @(negedge clk);
      repeat (4) begin
         @(negedge clk);
         if (ov8 !== 1'b0) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL b2b duplicate: got %0d extra results expected 0", extra); end
   endtask

   task automatic test_reset_midflight();
      logic [7:0] rs8; logic [15:0] rs16; logic rc, rv; int lat, seen;
      sg8 = 1'b0; st8 = 1'b0; sg16 = 1'b0; st16 = 1'b0;
      @(negedge clk);
      a16 = 16'h0100; b16 = 16'h0200; iv16 = 1'b1;
      @(negedge clk);
      a16 = 16'h0300; b16 = 16'h0400;
      a8 = 8'd7; b8 = 8'd8; iv8 = 1'b1;
      @(negedge clk);
      iv16 = 1'b0; iv8 = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (ov8 !== 1'b0 || ov16 !== 1'b0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL midflight discard: got %0d valid cycles expected 0", seen); end
      run16(16'h1234, 16'h1111, 1'b0, 1'b0, rs16, rc, rv, lat);
      checks++; if (rs16 !== 16'h2345) begin errors++; $display("FAIL midflight next16 sum: got %h expected 2345", rs16); end
      checks++; if (lat != 4)          begin errors++; $display("FAIL midflight next16 latency: got %0d expected 4", lat); end
      run8(8'd50, 8'd25, 1'b0, 1'b0, rs8, rc, rv, lat);
      checks++; if (rs8 !== 8'd75)     begin errors++; $display("FAIL midflight next8 sum: got %0d expected 75", rs8); end
   endtask

   task automatic test_wide16();
      logic [15:0] rs; logic rc, rv; int lat;
      run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, rv, lat);
      checks++; if (lat != 4)        begin errors++; $display("FAIL w16_wrap latency: got %0d expected 4", lat); end
      checks++; if (rs !== 16'h0000) begin errors++; $display("FAIL w16_wrap sum: got %h expected 0000", rs); end
      checks++; if (rc !== 1'b1)     begin errors++; $display("FAIL w16_wrap carry: got %b expected 1", rc); end
      checks++; if (rv !== 1'b1)     begin errors++; $display("FAIL w16_wrap ovf: got %b expected 1", rv); end
      run16(16'hFFFF, 16'h0001, 1'b0, 1'b1, rs, rc, rv, lat);
      checks++; if (rs !== 16'hFFFF) begin errors++; $display("FAIL w16_usat sum: got %h expected ffff", rs); end
      run16(16'h7FFF, 16'h0001, 1'b1, 1'b1, rs, rc, rv, lat);
      checks++; if (rs !== 16'h7FFF) begin errors++; $display("FAIL w16_ssat sum: got %h expected 7fff", rs); end
      checks++; if (rv !== 1'b1)     begin errors++; $display("FAIL w16_ssat ovf: got %b expected 1", rv); end
      checks++; if (rc !== 1'b0)     begin errors++; $display("FAIL w16_ssat carry: got %b expected 0", rc); end
      run16(16'hFFFF, 16'h0001, 1'b1, 1'b1, rs, rc, rv, lat);
      checks++; if (rs !== 16'h0000) begin errors++; $display("FAIL w16_sneg1 sum: got %h expected 0000", rs); end
      checks++; if (rv !== 1'b0)     begin errors++; $display("FAIL w16_sneg1 ovf: got %b expected 0", rv); end
      checks++; if (rc !== 1'b1)     begin errors++; $display("FAIL w16_sneg1 carry: got %b expected 1", rc); end
   endtask

   initial begin
      rst_n = 1'b0;
      iv8 = 1'b0; a8 = '0; b8 = '0; sg8 = 1'b0; st8 = 1'b0; or8 = 1'b1;
      iv16 = 1'b0; a16 = '0; b16 = '0; sg16 = 1'b0; st16 = 1'b0; or16 = 1'b1;
      test_reset();
      test_unsigned();
      test_signed();
      test_back_to_back();
      test_reset_midflight();
      test_wide16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000 expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
